// File: rtl/fft8_stream.sv
// fft8_stream: sequential 8-point radix-2 DIT FFT over real signed samples.
// Samples are loaded serially into a bit-reversed RAM. One shared butterfly unit
// runs the 12 butterflies in place, then the 8 complex bins stream out in natural
// order under valid/ready. Only one frame is in flight at a time.
module fft8_stream #(
  parameter int DW      = 4,
  parameter int OW      = DW + 3,
  parameter int TW_FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic [2:0]           out_idx,
  output logic                 out_last
);

  localparam int IW   = OW + 1;
  localparam int PW   = IW + TW_FRAC + 3;
  // round(sqrt(2)/2 * 2^TW_FRAC); 46341/65536 approximates sqrt(2)/2
  localparam int TW_C = (46341 * (1 << TW_FRAC) + 32768) >> 16;
  localparam logic signed [PW-1:0] TW_C_S  = PW'(TW_C);
  localparam logic signed [PW-1:0] TW_HALF = PW'(1 << (TW_FRAC - 1));
  localparam logic signed [IW-1:0] SAT_HI  = IW'((1 << (OW - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_LO  = IW'(-(1 << (OW - 1)));

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [IW-1:0] re_q [8];
  logic signed [IW-1:0] im_q [8];
  logic signed [IW-1:0] re_d [8];
  logic signed [IW-1:0] im_d [8];

  logic [1:0]           bf_stage, bf_b, bf_tw;
  logic [2:0]           bf_i, bf_j;
  logic signed [IW-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [IW:0]   s_pp, s_mp, s_nn;

  // x * C with round-half-up and arithmetic shift back to IW bits
  function automatic logic signed [IW-1:0] tw_mul(input logic signed [IW:0] x);
    logic signed [PW-1:0] p;
    p = PW'(x);
    p = p * TW_C_S + TW_HALF;
    return IW'(p >>> TW_FRAC);
  endfunction

  // clamp an internal value to the OW-bit output range
  function automatic logic signed [OW-1:0] sat_ow(input logic signed [IW-1:0] v);
    if (v > SAT_HI) return {1'b0, {(OW-1){1'b1}}};
    else if (v < SAT_LO) return {1'b1, {(OW-1){1'b0}}};
    else return v[OW-1:0];
  endfunction

  function automatic logic [2:0] rev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  // butterfly addressing and twiddle product for the current CALC step
  always_comb begin
    bf_stage = cnt_q[3:2];
    bf_b     = cnt_q[1:0];
    case (bf_stage)
      2'd0: begin
        bf_i  = {bf_b, 1'b0};
        bf_j  = {bf_b, 1'b1};
        bf_tw = 2'd0;
      end
      2'd1: begin
        bf_i  = {bf_b[1], 1'b0, bf_b[0]};
        bf_j  = {bf_b[1], 1'b1, bf_b[0]};
        bf_tw = {bf_b[0], 1'b0};
      end
      default: begin
        bf_i  = {1'b0, bf_b};
        bf_j  = {1'b1, bf_b};
        bf_tw = bf_b;
      end
    endcase
    a_re = re_q[bf_i];
    a_im = im_q[bf_i];
    b_re = re_q[bf_j];
    b_im = im_q[bf_j];
    s_pp = {b_re[IW-1], b_re} + {b_im[IW-1], b_im};
    s_mp = {b_im[IW-1], b_im} - {b_re[IW-1], b_re};
    s_nn = '0 - s_pp;
    case (bf_tw)
      2'd0: begin
        t_re = b_re;
        t_im = b_im;
      end
      2'd1: begin
        t_re = tw_mul(s_pp);
        t_im = tw_mul(s_mp);
      end
      2'd2: begin
        t_re = b_im;
        t_im = -b_re;
      end
      default: begin
        t_re = tw_mul(s_mp);
        t_im = tw_mul(s_nn);
      end
    endcase
  end

  // frame sequencing: load samples, run butterflies in place, stream bins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    re_d    = re_q;
    im_d    = im_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          re_d[rev3(cnt_q[2:0])] = {{(IW-DW){in_data[DW-1]}}, in_data};
          im_d[rev3(cnt_q[2:0])] = '0;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_CALC: begin
        re_d[bf_i] = a_re + t_re;
        im_d[bf_i] = a_im + t_im;
        re_d[bf_j] = a_re - t_re;
        im_d[bf_j] = a_im - t_im;
        if (cnt_q == 4'd11) begin
          cnt_d   = '0;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
    endcase
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_OUT);
  end

  // state, counters, handshake flags and sample RAM; reset aborts any frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      re_q        <= re_d;
      im_q        <= im_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_valid_q ? sat_ow(re_q[cnt_q[2:0]]) : '0;
  assign out_im    = out_valid_q ? sat_ow(im_q[cnt_q[2:0]]) : '0;
  assign out_idx   = out_valid_q ? cnt_q[2:0] : 3'd0;
  assign out_last  = out_valid_q && (cnt_q == 4'd7);

endmodule

// File: tb/tb_fft8_stream.sv
// tb_fft8_stream: scoreboard bench for fft8_stream (DW=4, OW=7, TW_FRAC=8).
module tb_fft8_stream;

  localparam int DW  = 4;
  localparam int OW  = 7;
  localparam int TWF = 8;

  typedef int frame_t [8];
  typedef struct {
    integer re;
    integer im;
    integer idx;
    integer last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic [2:0]           out_idx;
  logic                 out_last;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;

  frame_t x1   = '{2, 3, 0, 1, 0, 0, 0, 0};
  frame_t e1r  = '{6, 3, 2, 1, -2, 1, 2, 3};
  frame_t e1i  = '{0, -3, -2, -3, 0, 3, 2, 3};
  frame_t imp  = '{5, 0, 0, 0, 0, 0, 0, 0};
  frame_t impr = '{5, 5, 5, 5, 5, 5, 5, 5};
  frame_t zer  = '{0, 0, 0, 0, 0, 0, 0, 0};
  frame_t dc   = '{-8, -8, -8, -8, -8, -8, -8, -8};
  frame_t dcr  = '{-64, 0, 0, 0, 0, 0, 0, 0};
  frame_t m_re, m_im, xr;

  fft8_stream #(.DW(DW), .OW(OW), .TW_FRAC(TWF)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input integer got, input integer exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference: textbook in-place DIT with generic complex twiddle multiply
  task automatic model(input frame_t x);
    int ar[8], ai[8];
    int wr[4], wi[4];
    int half, i, j, t, pr, pim, tr, ti, nr, ni, rv;
    wr = '{256, 181, 0, -181};
    wi = '{0, -181, -256, -181};
    for (int n = 0; n < 8; n++) begin
      rv = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      ar[rv] = x[n];
      ai[rv] = 0;
    end
    for (int s = 0; s < 3; s++) begin
      half = 1 << s;
      for (int g = 0; g < 8; g += 2 * half) begin
        for (int k = 0; k < half; k++) begin
          i   = g + k;
          j   = i + half;
          t   = k << (2 - s);
          pr  = ar[j] * wr[t] - ai[j] * wi[t];
          pim = ar[j] * wi[t] + ai[j] * wr[t];
          tr  = (pr + (1 << (TWF - 1))) >>> TWF;
          ti  = (pim + (1 << (TWF - 1))) >>> TWF;
          nr  = ar[i] + tr;
          ni  = ai[i] + ti;
          ar[j] = ar[i] - tr;
          ai[j] = ai[i] - ti;
          ar[i] = nr;
          ai[i] = ni;
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      m_re[k] = (ar[k] > 63) ? 63 : (ar[k] < -64) ? -64 : ar[k];
      m_im[k] = (ai[k] > 63) ? 63 : (ai[k] < -64) ? -64 : ai[k];
    end
  endtask

  task automatic push_exp(input frame_t er, input frame_t ei);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.re   = er[k];
      e.im   = ei[k];
      e.idx  = k;
      e.last = (k == 7) ? 1 : 0;
      sb.push_back(e);
    end
  endtask

  // called at a negedge; returns at the negedge after the last accepting edge
  task automatic drive_samples(input frame_t x, input int cnt, input bit hold, input int nxt);
    bit acc;
    int guard;
    for (int n = 0; n < cnt; n++) begin
      in_data  = DW'(x[n]);
      in_valid = 1'b1;
      acc      = 1'b0;
      guard    = 0;
      while (!acc) begin
        acc = in_ready;
        @(negedge clk);
        guard++;
        if (guard > 500) begin
          $display("FAIL accept_timeout sample=%0d got=no_accept exp=accept", n);
          $fatal(1, "input stalled");
        end
      end
    end
    if (hold) in_data = DW'(nxt);
    else in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t x, input frame_t er, input frame_t ei,
                            input bit hold, input int nxt, input bit chk_low);
    int  cyc, lat, nlow;
    bit  done;
    push_exp(er, ei);
    drive_samples(x, 8, hold, nxt);
    cyc  = 0;
    lat  = -1;
    nlow = 0;
    done = 1'b0;
    for (int g = 0; g < 600; g++) begin
      cyc++;
      if (lat < 0 && out_valid) lat = cyc;
      if (in_ready) begin
        done = 1'b1;
        break;
      end
      nlow++;
      @(negedge clk);
    end
    chk("frame_done", done, 1);
    chk("latency", lat, 13);
    if (chk_low) chk("in_ready_low", nlow, 20);
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic rand_frame();
    for (int n = 0; n < 8; n++) xr[n] = int'($urandom_range(15)) - 8;
    model(xr);
  endtask

  // scoreboard monitor: every valid cycle is compared against the head entry
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      sb.delete();
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("extra_bin", out_idx, -1);
      end else begin
        chk("bin_re", out_re, sb[0].re);
        chk("bin_im", out_im, sb[0].im);
        chk("bin_idx", out_idx, sb[0].idx);
        chk("bin_last", out_last, sb[0].last);
        if (out_ready) sb.delete(0);
      end
    end
  end

  // consumer readiness: always ready, or a repeating 1-0-0-1 pattern
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        ph++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    send_frame(x1, e1r, e1i, 0, 0, 1);
    send_frame(imp, impr, zer, 0, 0, 1);
    send_frame(dc, dcr, zer, 0, 0, 1);

    rdy_mode = 1;
    send_frame(x1, e1r, e1i, 0, 0, 0);
    rand_frame();
    send_frame(xr, m_re, m_im, 0, 0, 0);
    rdy_mode = 0;

    repeat (3) begin
      rand_frame();
      send_frame(xr, m_re, m_im, 0, 0, 1);
    end

    drive_samples(x1, 5, 1, 0);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_load_out_valid", out_valid, 0);
    chk("rst_load_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_load_release", in_ready, 1);

    push_exp(e1r, e1i);
    drive_samples(x1, 8, 0, 0);
    hit = 1'b0;
    for (int g = 0; g < 100; g++) begin
      if (out_valid && out_idx == 3'd3) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_bin3", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid_k3", out_valid, 0);
    chk("rst_out_idx_k3", out_idx, 0);
    chk("rst_out_last_k3", out_last, 0);
    chk("rst_in_ready_k3", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_release", in_ready, 1);
    send_frame(x1, e1r, e1i, 0, 0, 1);

    send_frame(x1, e1r, e1i, 1, imp[0], 1);
    send_frame(imp, impr, zer, 0, 0, 1);

    repeat (3) @(negedge clk);
    chk("final_drain", sb.size(), 0);
    chk("final_out_valid", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
